data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Load/store stage directly downstream of the ALU: takes the computed effective address (ALU result) plus store data and load/store control from the single-cycle datapath.
- Drives a word-wide external data-memory bus with a req/ack handshake.
- Stalls the CPU until the access completes, then returns the aligned, sign/zero-extended load data.
- Flags misaligned or illegal sizes and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent in WAIT_ACK before the access aborts with bus error (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  access request; held high with all cpu_* inputs stable while cpu_stall=1
- cpu_we  input  1  1=store, 0=load
- cpu_funct3  input  3  [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2]=1 zero-extend load
- cpu_addr  input  32  effective byte address (ALU result)
- cpu_wdata  input  32  store data (rs2), low bits used for sub-word
- cpu_stall  output  1  freeze PC and writeback
- cpu_done  output  1  one-cycle completion pulse
- cpu_rdata  output  32  extended load data, valid when cpu_done
- cpu_misalign  output  1  with cpu_done: misaligned or illegal size, no bus access made
- cpu_bus_err  output  1  with cpu_done: timeout
- mem_req  output  1  bus request, registered
- mem_we  output  1  bus write enable
- mem_addr  output  32  word address {cpu_addr[31:2],2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  one-cycle completion from memory
- mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- Reset (async, any state): state=IDLE; every registered output 0; counter 0; mem_req drops immediately.
- States: IDLE, WAIT_ACK, DONE.
- IDLE + cpu_req:
  - Illegal size (11), half with addr[0]=1, or word with addr[1:0]!=0 -> DONE with misalign=1; mem_req never asserted.
  - Otherwise -> WAIT_ACK; register mem_req=1 and mem_we, mem_addr, mem_be, mem_wdata.
- mem_be:
  - byte -> 4'b0001<<addr[1:0]
  - half -> addr[1]? 1100 : 0011
  - word -> 1111
- mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- WAIT_ACK:
  - mem_req and all mem_* outputs held stable until ack; counter increments each cycle.
  - mem_ack=1 -> mem_req=0, DONE. For loads, capture extracted data: shift mem_rdata right by addr[1:0]*8, then sign-extend bit 7/15 (funct3[2]=0) or zero-extend (funct3[2]=1).
  - No ack and counter==TIMEOUT_CYCLES-1 -> mem_req=0, DONE with bus_err=1.
  - Ack on the timeout cycle: ack wins, no error.
- DONE:
  - cpu_done=1 for exactly one cycle, flags as set; unconditional -> IDLE.
  - cpu_rdata = loaded value; 0 for stores and errors. Holds until the next DONE.
  - misalign and bus_err are 0 outside DONE.
- cpu_stall (combinational) = (state==IDLE & cpu_req) | (state==WAIT_ACK). It is 0 in DONE, so the CPU advances at the end of the DONE cycle.
- A new request is accepted only in IDLE; cpu_req high in DONE is the same instruction and is ignored.
- mem_ack outside WAIT_ACK: ignored.
- Latency from cpu_req (cycle 0):
  - misaligned -> done at cycle 1
  - ack in first WAIT_ACK cycle -> done at cycle 2
  - general: done = ack cycle + 1
  - timeout -> done at cycle TIMEOUT_CYCLES+1
- No back-to-back overlap: at most one outstanding bus transaction.

Test Plan:
- Word load at 0x100, ack on 1st WAIT_ACK cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, done at cycle 2, rdata=0xDEADBEEF, stall high on cycles 0-1.
- LB at 0x103, rdata=0x80000000 -> be=1000, rdata=0xFFFFFF80. LBU same -> 0x00000080. LHU at 0x102 with 0xABCD0000 -> 0x0000ABCD.
- SH at 0x206, wdata=0x12345678, ack after 3 cycles -> mem_addr=0x204, be=1100, mem_wdata=0x56785678, mem_we=1, done at cycle 4, rdata=0.
- LW at 0x101, SH at 0x201, and funct3 size 11 -> mem_req never high; done+misalign at cycle 1.
- No ack with TIMEOUT_CYCLES=16 -> mem_req high cycles 1-16, drops at cycle 17; done+bus_err at cycle 17. Repeat with ack on cycle 16 -> no error.
- rst_n low mid-WAIT_ACK -> mem_req/stall/done 0 immediately. After release, a stray mem_ack is ignored and a new LW completes normally.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Word-wide data-memory bus with a single-cycle ack handshake.
// The controller drives the request side; the memory answers with ack/rdata.
`timescale 1ns/1ps
interface data_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store stage: turns an ALU effective address into one word-bus access,
// stalls the CPU until it completes, and returns extended load data or an error flag.
`timescale 1ns/1ps
module data_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [2:0]           cpu_funct3,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_stall,
    output logic                 cpu_done,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_misalign,
    output logic                 cpu_bus_err,
    data_mem_ctrl_if.master      mem
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      size_q;
    logic [1:0]      off_q;
    logic            unsigned_q;
    logic            misalign_q;
    logic            bus_err_q;
    logic [31:0]     rdata_q;

    logic [1:0]      req_size;
    logic            req_bad;
    logic [3:0]      req_be;
    logic [31:0]     req_wdata;
    logic            timeout_hit;
    logic [31:0]     shifted;
    logic [31:0]     load_data;
    logic            start_bus, finish_ack, finish_to, finish_mis;

    assign req_size    = cpu_funct3[1:0];
    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_bad   = 1'b0;
        req_be    = 4'b1111;
        req_wdata = cpu_wdata;
        unique case (req_size)
            SZ_BYTE: begin
                req_be    = 4'b0001 << cpu_addr[1:0];
                req_wdata = {4{cpu_wdata[7:0]}};
            end
            SZ_HALF: begin
                req_bad   = cpu_addr[0];
                req_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{cpu_wdata[15:0]}};
            end
            SZ_WORD: req_bad = (cpu_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Move the addressed lane down to bit 0, then extend from the access size.
    always_comb begin
        shifted   = mem.mem_rdata >> {off_q, 3'b000};
        load_data = shifted;
        case (size_q)
            SZ_BYTE: load_data = {{24{~unsigned_q & shifted[7]}},  shifted[7:0]};
            SZ_HALF: load_data = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        start_bus  = 1'b0;
        finish_ack = 1'b0;
        finish_to  = 1'b0;
        finish_mis = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (req_bad) begin
                        state_d    = DONE;
                        finish_mis = 1'b1;
                    end else begin
                        state_d    = WAIT_ACK;
                        start_bus  = 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                // An ack landing on the last allowed cycle still completes cleanly.
                if (mem.mem_ack) begin
                    state_d    = DONE;
                    finish_ack = 1'b1;
                end else if (timeout_hit) begin
                    state_d    = DONE;
                    finish_to  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            size_q        <= '0;
            off_q         <= '0;
            unsigned_q    <= 1'b0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
            rdata_q       <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
        end else begin
            state_q <= state_d;

            if (start_bus) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= cpu_we;
                mem.mem_addr  <= {cpu_addr[31:2], 2'b00};
                mem.mem_be    <= req_be;
                mem.mem_wdata <= req_wdata;
                size_q        <= req_size;
                off_q         <= cpu_addr[1:0];
                unsigned_q    <= cpu_funct3[2];
                cnt_q         <= '0;
            end else if (state_q == WAIT_ACK) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (finish_ack || finish_to) begin
                mem.mem_req <= 1'b0;
            end

            if (finish_ack) begin
                rdata_q <= mem.mem_we ? 32'h0 : load_data;
            end
            if (finish_to) begin
                bus_err_q <= 1'b1;
                rdata_q   <= 32'h0;
            end
            if (finish_mis) begin
                misalign_q <= 1'b1;
                rdata_q    <= 32'h0;
            end

            // Flags are only meaningful alongside cpu_done.
            if (state_q == DONE) begin
                misalign_q <= 1'b0;
                bus_err_q  <= 1'b0;
            end
        end
    end

    assign cpu_stall    = ((state_q == IDLE) && cpu_req) || (state_q == WAIT_ACK);
    assign cpu_done     = (state_q == DONE);
    assign cpu_rdata    = rdata_q;
    assign cpu_misalign = misalign_q;
    assign cpu_bus_err  = bus_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed accesses push expected results,
// a memory responder and a completion monitor check them independently.
`timescale 1ns/1ps
module tb_data_mem_ctrl;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_funct3 = 3'b000;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_stall, cpu_done, cpu_misalign, cpu_bus_err;
    logic [31:0] cpu_rdata;

    data_mem_ctrl_if bus();

    data_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_funct3   (cpu_funct3),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_stall    (cpu_stall),
        .cpu_done     (cpu_done),
        .cpu_rdata    (cpu_rdata),
        .cpu_misalign (cpu_misalign),
        .cpu_bus_err  (cpu_bus_err),
        .mem          (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        int          start;
        int          lat;
        logic [31:0] rdata;
        logic        mis;
        logic        err;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          ack_after;  // 0 = never ack
        int          len;        // expected cycles with mem_req high
    } bus_t;

    res_t sb_q[$];
    bus_t bus_q[$];

    // Memory responder: checks the request on first sight, acks after ack_after cycles.
    logic ack_now = 1'b0;
    logic stray   = 1'b0;
    bus_t cur;
    int   w    = 0;
    bit   busy = 1'b0;

    assign bus.mem_ack = ack_now | stray;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy          = 1'b0;
            w             = 0;
            ack_now       = 1'b0;
            bus.mem_rdata = 32'h0;
        end else if (bus.mem_req) begin
            if (!busy) begin
                busy = 1'b1;
                w    = 0;
                if (bus_q.size() == 0) begin
                    check("mem_req_unexpected", 32'd1, 32'd0);
                    cur.addr = 0; cur.be = 0; cur.we = 0; cur.wdata = 0;
                    cur.rword = 0; cur.ack_after = 1; cur.len = 1;
                end else begin
                    cur = bus_q.pop_front();
                    check("mem_addr", bus.mem_addr, cur.addr);
                    check("mem_be", 32'(bus.mem_be), 32'(cur.be));
                    check("mem_we", 32'(bus.mem_we), 32'(cur.we));
                    if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
                end
            end
            w++;
            ack_now       = (cur.ack_after != 0) && (w == cur.ack_after);
            bus.mem_rdata = cur.rword;
        end else begin
            if (busy) check("mem_req_cycles", 32'(w), 32'(cur.len));
            busy    = 1'b0;
            w       = 0;
            ack_now = 1'b0;
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_done) begin
                if (sb_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = sb_q.pop_front();
                    check("done_latency", 32'(cyc - e.start), 32'(e.lat));
                    check("cpu_rdata", cpu_rdata, e.rdata);
                    check("cpu_misalign", 32'(cpu_misalign), 32'(e.mis));
                    check("cpu_bus_err", 32'(cpu_bus_err), 32'(e.err));
                    check("stall_in_done", 32'(cpu_stall), 32'd0);
                end
            end else if (sb_q.size() != 0 && cyc >= sb_q[0].start) begin
                check("stall_while_busy", 32'(cpu_stall), 32'd1);
                check("flags_outside_done", {30'd0, cpu_misalign, cpu_bus_err}, 32'd0);
            end
        end
    end

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rword, input int ack_after,
                       input logic [31:0] maddr, input logic [3:0] be, input logic [31:0] mwdata,
                       input logic mis, input logic err, input logic [31:0] exp_rdata, input int lat);
        res_t r;
        bus_t b;
        bit   seen;
        @(posedge clk); #1;
        r.start = cyc; r.lat = lat; r.rdata = exp_rdata; r.mis = mis; r.err = err;
        sb_q.push_back(r);
        if (!mis) begin
            b.addr = maddr; b.be = be; b.we = we; b.wdata = mwdata; b.rword = rword;
            b.ack_after = ack_after;
            b.len = (ack_after == 0) ? TO : ack_after;
            bus_q.push_back(b);
        end
        cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wdata;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_done", 32'(cpu_done), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_misalign", 32'(cpu_misalign), 32'd0);
        check("rst_bus_err", 32'(cpu_bus_err), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_be", 32'(bus.mem_be), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;

        //   we  f3      addr          wdata         rword         ack  maddr         be       mwdata        mis err rdata         lat
        txn(0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1,  32'h0000_0100, 4'b1111, 32'h0,        0, 0, 32'hDEAD_BEEF, 2);
        txn(0, 3'b000, 32'h0000_0103, 32'h0,        32'h8000_0000, 1,  32'h0000_0100, 4'b1000, 32'h0,        0, 0, 32'hFFFF_FF80, 2);
        txn(0, 3'b100, 32'h0000_0103, 32'h0,        32'h8000_0000, 1,  32'h0000_0100, 4'b1000, 32'h0,        0, 0, 32'h0000_0080, 2);
        txn(0, 3'b101, 32'h0000_0102, 32'h0,        32'hABCD_0000, 1,  32'h0000_0100, 4'b1100, 32'h0,        0, 0, 32'h0000_ABCD, 2);
        txn(0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 2,  32'h0000_0100, 4'b1100, 32'h0,        0, 0, 32'hFFFF_8001, 3);
        txn(0, 3'b000, 32'h0000_0100, 32'h0,        32'h1234_567F, 1,  32'h0000_0100, 4'b0001, 32'h0,        0, 0, 32'h0000_007F, 2);
        txn(1, 3'b001, 32'h0000_0206, 32'h1234_5678, 32'hFFFF_FFFF, 3, 32'h0000_0204, 4'b1100, 32'h5678_5678, 0, 0, 32'h0,        4);
        txn(1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'hFFFF_FFFF, 2, 32'h0000_0100, 4'b0010, 32'hABAB_ABAB, 0, 0, 32'h0,        3);
        txn(1, 3'b010, 32'h0000_0208, 32'hA5A5_0F0F, 32'hFFFF_FFFF, 1, 32'h0000_0208, 4'b1111, 32'hA5A5_0F0F, 0, 0, 32'h0,        2);
        txn(0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         1,  32'h0,         4'b0000, 32'h0,        1, 0, 32'h0,         1);
        txn(1, 3'b001, 32'h0000_0201, 32'hFFFF_FFFF, 32'h0,        1,  32'h0,         4'b0000, 32'h0,        1, 0, 32'h0,         1);
        txn(0, 3'b011, 32'h0000_0200, 32'h0,        32'h0,         1,  32'h0,         4'b0000, 32'h0,        1, 0, 32'h0,         1);
        txn(0, 3'b010, 32'h0000_0110, 32'h0,        32'h1111_2222, 0,  32'h0000_0110, 4'b1111, 32'h0,        0, 1, 32'h0,         TO + 1);
        txn(0, 3'b010, 32'h0000_0104, 32'h0,        32'h1357_9BDF, TO, 32'h0000_0104, 4'b1111, 32'h0,        0, 0, 32'h1357_9BDF, TO + 1);

        // Reset in the middle of an outstanding access that never gets acked.
        begin
            bus_t b;
            @(posedge clk); #1;
            b.addr = 32'h0000_0400; b.be = 4'b1111; b.we = 1'b0; b.wdata = 32'h0;
            b.rword = 32'h0; b.ack_after = 0; b.len = TO;
            bus_q.push_back(b);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h0000_0400;
        end
        repeat (3) @(posedge clk);
        #3;
        check("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("async_rst_stall", 32'(cpu_stall), 32'd0);
        check("async_rst_done", 32'(cpu_done), 32'd0);
        bus_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        @(posedge clk); #1;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_ack_done", 32'(cpu_done), 32'd0);
            check("stray_ack_req", 32'(bus.mem_req), 32'd0);
        end

        txn(0, 3'b010, 32'h0000_0300, 32'h0,        32'hCAFE_F00D, 1,  32'h0000_0300, 4'b1111, 32'h0,        0, 0, 32'hCAFE_F00D, 2);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
